// File: rtl/dits_pkg.sv
// Shared constants for the Morse dit/dah front end: symbol codes, FSM states and
// run-length thresholds in time units (one unit = one bigclk sample).
package dits_pkg;

  localparam int CODE_W     = 3;
  localparam int DITS_CNT_W = 4;
  localparam int DAH_MIN    = 3;
  localparam int LETTER_GAP = 3;
  localparam int WORD_GAP   = 7;
  localparam int DAH_MAX    = 5;

  localparam logic [CODE_W-1:0] CODE_NONE       = 3'b000;
  localparam logic [CODE_W-1:0] CODE_DIT        = 3'b001;
  localparam logic [CODE_W-1:0] CODE_DAH        = 3'b010;
  localparam logic [CODE_W-1:0] CODE_LETTER_END = 3'b011;
  localparam logic [CODE_W-1:0] CODE_WORD_END   = 3'b100;
  localparam logic [CODE_W-1:0] CODE_ERROR      = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MARK      = 2'd1,
    S_SPACE     = 2'd2,
    S_WORD_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dits_run_counter.sv
// Saturating run-length counter: i_clear loads 1 (first sample of a new run),
// i_inc advances and sticks at the all-ones value.
module dits_run_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] LP_MAX = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= CNT_W'(1);
    end else if (i_inc && (r_count != LP_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dits_machine.sv
// Morse front end: classifies mark/space run lengths into one-cycle symbol codes.
// Optional DITS_ERR_EN: over-long marks report ERROR instead of DAH.
module dits_machine
  import dits_pkg::*;
#(
  parameter int CNT_W = DITS_CNT_W
) (
  input  logic        bigclk,
  input  logic        reset,
  input  logic        signal,
  output logic [2:0]  ditsdahs,
  output logic [1:0]  o_dbg_state
);

  localparam logic [CNT_W-1:0] LP_DAH_MIN   = CNT_W'(DAH_MIN);
  localparam logic [CNT_W-1:0] LP_LETTER_M1 = CNT_W'(LETTER_GAP - 1);
  localparam logic [CNT_W-1:0] LP_WORD_M1   = CNT_W'(WORD_GAP - 1);

  state_t            r_state;
  logic [CODE_W-1:0] r_code;
  logic [CNT_W-1:0]  w_count;
  logic              w_clear;
  logic              w_inc;

  function automatic logic [CODE_W-1:0] classify_mark(input logic [CNT_W-1:0] cnt);
    logic [CODE_W-1:0] code;
    code = (cnt < LP_DAH_MIN) ? CODE_DIT : CODE_DAH;
`ifdef DITS_ERR_EN
    if (cnt > CNT_W'(DAH_MAX)) code = CODE_ERROR;
`endif
    return code;
  endfunction

  // Every run starts by loading 1; staying in the same run level increments.
  always_comb begin
    w_clear = 1'b0;
    w_inc   = 1'b0;
    case (r_state)
      S_MARK:  begin w_inc = signal;  w_clear = ~signal; end
      S_SPACE: begin w_inc = ~signal; w_clear = signal;  end
      default: w_clear = signal;
    endcase
  end

  dits_run_counter #(.CNT_W(CNT_W)) u_run_counter (
    .clk     (bigclk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_inc   (w_inc),
    .o_count (w_count)
  );

  always_ff @(posedge bigclk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_code  <= CODE_NONE;
    end else begin
      r_code <= CODE_NONE;
      case (r_state)
        S_MARK: begin
          if (!signal) begin
            r_state <= S_SPACE;
            r_code  <= classify_mark(w_count);
          end
        end
        S_SPACE: begin
          if (signal) begin
            r_state <= S_MARK;
          end else if (w_count == LP_LETTER_M1) begin
            r_code <= CODE_LETTER_END;
          end else if (w_count == LP_WORD_M1) begin
            r_code  <= CODE_WORD_END;
            r_state <= S_WORD_DONE;
          end
        end
        default: begin
          if (signal) r_state <= S_MARK;
        end
      endcase
    end
  end

  assign ditsdahs    = r_code;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dits_machine.sv
// Directed bench for dits_machine; expected codes are hand-computed per sample.
// Build with +define+DITS_ERR_EN to check the over-long mark ERROR variant.
module tb_dits_machine;
  import dits_pkg::*;

  logic       bigclk;
  logic       reset;
  logic       signal;
  logic [2:0] ditsdahs;
  logic [1:0] o_dbg_state;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] E_NONE = 3'b000;
  localparam logic [2:0] E_DIT  = 3'b001;
  localparam logic [2:0] E_DAH  = 3'b010;
  localparam logic [2:0] E_LE   = 3'b011;
  localparam logic [2:0] E_WE   = 3'b100;
`ifdef DITS_ERR_EN
  localparam logic [2:0] E_LONG = 3'b101;
`else
  localparam logic [2:0] E_LONG = 3'b010;
`endif
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MARK = 2'd1;
  localparam logic [1:0] ST_WD   = 2'd3;

  dits_machine dut (
    .bigclk      (bigclk),
    .reset       (reset),
    .signal      (signal),
    .ditsdahs    (ditsdahs),
    .o_dbg_state (o_dbg_state)
  );

  initial bigclk = 1'b0;
  always #5 bigclk = ~bigclk;

  task automatic drive(input logic s);
    signal = s;
    @(posedge bigclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0);
    drive(1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1);
      total++;
      if (ditsdahs !== E_NONE || o_dbg_state !== ST_IDLE) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got code=%b state=%0d expected code=000 state=0", i, ditsdahs, o_dbg_state);
      end
    end
    reset = 1'b0;
    drive(1'b1);
    total++;
    if (ditsdahs !== E_NONE || o_dbg_state !== ST_MARK) begin
      bad++;
      $display("FAIL reset_first_mark: got code=%b state=%0d expected code=000 state=1", ditsdahs, o_dbg_state);
    end
    drive(1'b0);
    total++;
    if (ditsdahs !== E_DIT) begin
      bad++;
      $display("FAIL reset_count_is_1: got %b expected %b", ditsdahs, E_DIT);
    end
  endtask

  task automatic test_sequence();
    logic       seq [17] = '{1,0,1,1,1,0,0,0,1,0,0,0,0,0,0,0,1};
    logic [2:0] exp [17];
    for (int i = 0; i < 17; i++) exp[i] = E_NONE;
    exp[1] = E_DIT; exp[5] = E_DAH; exp[7] = E_LE;
    exp[9] = E_DIT; exp[11] = E_LE; exp[15] = E_WE;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(seq[i]);
      total++;
      if (ditsdahs !== exp[i]) begin
        bad++;
        $display("FAIL sequence[cycle %0d]: got %b expected %b", i + 1, ditsdahs, exp[i]);
      end
    end
  endtask

  task automatic test_idle_line();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0);
      total++;
      if (ditsdahs !== E_NONE || o_dbg_state !== ST_IDLE) begin
        bad++;
        $display("FAIL idle_line[%0d]: got code=%b state=%0d expected code=000 state=0", i, ditsdahs, o_dbg_state);
      end
    end
  endtask

  // Mark of n samples then one space; returns the code seen after the space.
  task automatic mark_then_space(input int n, output logic [2:0] code, output int noise);
    noise = 0;
    do_reset();
    for (int i = 0; i < n; i++) begin
      drive(1'b1);
      if (ditsdahs !== E_NONE) noise++;
    end
    drive(1'b0);
    code = ditsdahs;
  endtask

  task automatic test_mark_lengths();
    int         lens [6] = '{1, 2, 3, 5, 6, 20};
    logic [2:0] exps [6];
    logic [2:0] got;
    int         noise;
    exps = '{E_DIT, E_DIT, E_DAH, E_DAH, E_LONG, E_LONG};
    for (int k = 0; k < 6; k++) begin
      mark_then_space(lens[k], got, noise);
      total++;
      if (got !== exps[k] || noise != 0) begin
        bad++;
        $display("FAIL mark_len_%0d: got %b (stray codes %0d) expected %b", lens[k], got, noise, exps[k]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [2:0] exp;
    do_reset();
    drive(1'b1);
    drive(1'b0);
    for (int i = 2; i <= 12; i++) begin
      drive(1'b0);
      exp = (i == 3) ? E_LE : (i == 7) ? E_WE : E_NONE;
      total++;
      if (ditsdahs !== exp) begin
        bad++;
        $display("FAIL gap_space_%0d: got %b expected %b", i, ditsdahs, exp);
      end
    end
    total++;
    if (o_dbg_state !== ST_WD) begin
      bad++;
      $display("FAIL gap_word_done_state: got %0d expected %0d", o_dbg_state, ST_WD);
    end
    drive(1'b1);
    drive(1'b1);
    drive(1'b0);
    total++;
    if (ditsdahs !== E_DIT) begin
      bad++;
      $display("FAIL gap_after_word: got %b expected %b", ditsdahs, E_DIT);
    end
  endtask

  task automatic test_reset_mid_dah();
    do_reset();
    drive(1'b1);
    drive(1'b1);
    drive(1'b1);
    reset = 1'b1;
    drive(1'b0);
    reset = 1'b0;
    total++;
    if (ditsdahs !== E_NONE || o_dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_on_dah_edge: got code=%b state=%0d expected code=000 state=0", ditsdahs, o_dbg_state);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0);
      total++;
      if (ditsdahs !== E_NONE) begin
        bad++;
        $display("FAIL reset_no_gap_codes[%0d]: got %b expected 000", i, ditsdahs);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    signal = 1'b0;
    test_reset();
    test_sequence();
    test_idle_line();
    test_mark_lengths();
    test_gaps();
    test_reset_mid_dah();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
